// File: rtl/gpio_pad_bank.sv
// N-channel GPIO pad controller: registered pad drive with self-timed output pulses,
// plus input synchronisation, edge detection and sticky edge status with a summed interrupt.
module gpio_pad_bank #(
  parameter int unsigned NUM_GPIO    = 11,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PULSE_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_GPIO-1:0] dir_i,
  input  logic [NUM_GPIO-1:0] out_i,
  input  logic [NUM_GPIO-1:0] pulse_start_i,
  input  logic [PULSE_W-1:0]  pulse_len_i,
  output logic [NUM_GPIO-1:0] pulse_busy_o,
  output logic [NUM_GPIO-1:0] pad_oe_o,
  output logic [NUM_GPIO-1:0] pad_out_o,
  input  logic [NUM_GPIO-1:0] pad_in_i,
  output logic [NUM_GPIO-1:0] in_o,
  output logic [NUM_GPIO-1:0] rise_o,
  output logic [NUM_GPIO-1:0] fall_o,
  input  logic [NUM_GPIO-1:0] irq_en_rise_i,
  input  logic [NUM_GPIO-1:0] irq_en_fall_i,
  input  logic [NUM_GPIO-1:0] irq_clr_i,
  output logic [NUM_GPIO-1:0] irq_status_o,
  output logic                irq_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } chan_state_e;

  localparam int unsigned MASK_CYC = SYNC_STAGES + 1;
  localparam int unsigned MASK_W   = $clog2(MASK_CYC + 1);

  chan_state_e         state_q [NUM_GPIO];
  chan_state_e         state_d [NUM_GPIO];
  logic [PULSE_W-1:0]  cnt_q   [NUM_GPIO];
  logic [PULSE_W-1:0]  cnt_d   [NUM_GPIO];
  logic [NUM_GPIO-1:0] pad_oe_q, pad_oe_d;
  logic [NUM_GPIO-1:0] pad_out_q, pad_out_d;

  logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_GPIO-1:0] in_prev_q;
  logic [MASK_W-1:0]   mask_cnt_q, mask_cnt_d;
  logic                edge_en;
  logic [NUM_GPIO-1:0] irq_status_q, irq_status_d;
  logic [NUM_GPIO-1:0] irq_set;

  // Per-channel pulse FSM. The pad registers are loaded from the next state so the
  // pulse appears the cycle after the request and lasts exactly pulse_len_i cycles.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
    for (int k = 0; k < NUM_GPIO; k++) begin
      state_d[k]   = state_q[k];
      cnt_d[k]     = cnt_q[k];
      pad_oe_d[k]  = dir_i[k];
      pad_out_d[k] = out_i[k] & dir_i[k];
      case (state_q[k])
        ST_IDLE: begin
          if (pulse_start_i[k] && (pulse_len_i != '0)) begin
            state_d[k]   = ST_PULSE;
            cnt_d[k]     = pulse_len_i;
            pad_oe_d[k]  = 1'b1;
            pad_out_d[k] = 1'b1;
          end
        end
        ST_PULSE: begin
          if (cnt_q[k] == PULSE_W'(1)) begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end else begin
            cnt_d[k]     = cnt_q[k] - PULSE_W'(1);
            pad_oe_d[k]  = 1'b1;
            pad_out_d[k] = 1'b1;
          end
        end
        default: state_d[k] = ST_IDLE;
      endcase
    end
  end

  // Edge outputs stay masked until the synchroniser and in_prev hold real pad samples.
  always_comb begin
    mask_cnt_d = mask_cnt_q;
    if (mask_cnt_q != MASK_W'(MASK_CYC)) begin
      mask_cnt_d = mask_cnt_q + MASK_W'(1);
    end
  end

  assign edge_en = (mask_cnt_q == MASK_W'(MASK_CYC));
  assign in_o    = sync_q[SYNC_STAGES-1];
  assign rise_o  = in_o & ~in_prev_q & {NUM_GPIO{edge_en}};
  assign fall_o  = ~in_o & in_prev_q & {NUM_GPIO{edge_en}};

  // A set in the same cycle as a clear wins.
  assign irq_set      = (rise_o & irq_en_rise_i) | (fall_o & irq_en_fall_i);
  assign irq_status_d = (irq_status_q & ~irq_clr_i) | irq_set;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      for (int k = 0; k < NUM_GPIO; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      pad_oe_q     <= '0;
      pad_out_q    <= '0;
      in_prev_q    <= '0;
      mask_cnt_q   <= '0;
      irq_status_q <= '0;
    end else begin
      for (int k = 0; k < NUM_GPIO; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      sync_q[0] <= pad_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      pad_oe_q     <= pad_oe_d;
      pad_out_q    <= pad_out_d;
      in_prev_q    <= in_o;
      mask_cnt_q   <= mask_cnt_d;
      irq_status_q <= irq_status_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_GPIO; k++) begin
      pulse_busy_o[k] = (state_q[k] == ST_PULSE);
    end
  end

  assign pad_oe_o     = pad_oe_q;
  assign pad_out_o    = pad_out_q;
  assign irq_status_o = irq_status_q;
  assign irq_o        = |irq_status_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Directed bench for gpio_pad_bank: table-driven static output/loopback vectors plus
// hand-written pulse, edge/status, collision and reset sequences.
module tb_gpio_pad_bank;

  localparam int N  = 11;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  dir, out, pulse_start, pad_oe, pad_out, pad_in, pad_ext, busy;
  logic [N-1:0]  in_sync, rise, fall, en_rise, en_fall, clr, status;
  logic [PW-1:0] pulse_len;
  logic          irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Pad model: a driving channel reads back its own value, a released one sees the external level.
  assign pad_in = (pad_oe & pad_out) | (~pad_oe & pad_ext);

  gpio_pad_bank #(.NUM_GPIO(N), .SYNC_STAGES(2), .PULSE_W(PW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dir_i         (dir),
    .out_i         (out),
    .pulse_start_i (pulse_start),
    .pulse_len_i   (pulse_len),
    .pulse_busy_o  (busy),
    .pad_oe_o      (pad_oe),
    .pad_out_o     (pad_out),
    .pad_in_i      (pad_in),
    .in_o          (in_sync),
    .rise_o        (rise),
    .fall_o        (fall),
    .irq_en_rise_i (en_rise),
    .irq_en_fall_i (en_fall),
    .irq_clr_i     (clr),
    .irq_status_o  (status),
    .irq_o         (irq)
  );

  typedef struct packed {
    logic [N-1:0] dir;
    logic [N-1:0] out;
    logic [N-1:0] exp_oe;
    logic [N-1:0] exp_out;
    logic [N-1:0] exp_in;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rise_seen;
    logic         irq_seen;

    vecs[0] = '{dir: 11'h00F, out: 11'h005, exp_oe: 11'h00F, exp_out: 11'h005, exp_in: 11'h005};
    vecs[1] = '{dir: 11'h7FF, out: 11'h2AA, exp_oe: 11'h7FF, exp_out: 11'h2AA, exp_in: 11'h2AA};
    vecs[2] = '{dir: 11'h0F0, out: 11'h0FF, exp_oe: 11'h0F0, exp_out: 11'h0F0, exp_in: 11'h0F0};
    vecs[3] = '{dir: 11'h000, out: 11'h7FF, exp_oe: 11'h000, exp_out: 11'h000, exp_in: 11'h000};
    vecs[4] = '{dir: 11'h400, out: 11'h555, exp_oe: 11'h400, exp_out: 11'h400, exp_in: 11'h400};

    rst_n = 1'b0; dir = '0; out = '0; pulse_start = '0; pulse_len = '0;
    pad_ext = 11'h7FF; en_rise = '1; en_fall = '0; clr = '0;

    // 1. Reset with all pads high: no rise/irq afterwards, in_o follows after 2 cycles.
    tick(3);
    check("reset pad_oe", 32'(pad_oe), 32'h0);
    check("reset pad_out", 32'(pad_out), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset in_o", 32'(in_sync), 32'h0);
    check("reset edges", 32'({rise, fall}), 32'h0);
    check("reset status/irq", 32'({status, irq}), 32'h0);
    rst_n = 1'b1;
    rise_seen = '0; irq_seen = 1'b0;
    tick();
    rise_seen |= rise; irq_seen |= irq;
    check("in_o latency 1", 32'(in_sync), 32'h0);
    tick();
    rise_seen |= rise; irq_seen |= irq;
    check("in_o after 2", 32'(in_sync), 32'h7FF);
    for (int i = 0; i < 18; i++) begin
      tick();
      rise_seen |= rise; irq_seen |= irq;
    end
    check("no rise after reset", 32'(rise_seen), 32'h0);
    check("no irq after reset", 32'(irq_seen), 32'h0);
    check("pad released after reset", 32'(pad_oe), 32'h0);
    en_rise = '0; pad_ext = '0;
    tick(4);
    check("no status from disabled fall", 32'(status), 32'h0);

    // 2. Static output and loopback, table-driven.
    for (int v = 0; v < 5; v++) begin
      dir = vecs[v].dir; out = vecs[v].out;
      tick();
      check($sformatf("vec%0d pad_oe", v), 32'(pad_oe), 32'(vecs[v].exp_oe));
      check($sformatf("vec%0d pad_out", v), 32'(pad_out), 32'(vecs[v].exp_out));
      tick(2);
      check($sformatf("vec%0d in_o", v), 32'(in_sync), 32'(vecs[v].exp_in));
    end
    dir = '0; out = '0;
    tick(4);

    // 3. Pulse of 5 cycles on channel 4; a restart in cycle 2 is ignored.
    pulse_len = 8'd5; pulse_start = 11'h010;
    tick();
    pulse_start = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("pulse cyc%0d busy/oe/out", i + 1),
            32'({busy[4], pad_oe[4], pad_out[4]}), 32'h7);
      if (i == 1) begin
        pulse_start = 11'h010; pulse_len = 8'd9;
        tick();
        pulse_start = '0; pulse_len = 8'd5;
      end else begin
        tick();
      end
    end
    check("pulse end busy/oe/out", 32'({busy[4], pad_oe[4], pad_out[4]}), 32'h0);
    tick(3);
    check("pulse no retrigger", 32'({busy[4], pad_oe[4]}), 32'h0);
    pulse_len = 8'd0; pulse_start = 11'h010;
    tick();
    pulse_start = '0;
    check("len0 no pulse", 32'({busy[4], pad_oe[4], pad_out[4]}), 32'h0);
    tick(2);
    check("len0 no pulse later", 32'({busy[4], pad_oe[4]}), 32'h0);
    tick(4);

    // 4. Rise edge on channel 8 sets status; clear; fall with fall disabled sets nothing.
    en_rise = 11'h100; pad_ext = 11'h100;
    tick();
    check("ch8 rise early", 32'(rise[8]), 32'h0);
    tick();
    check("ch8 rise", 32'(rise), 32'h100);
    check("ch8 status not yet", 32'(status), 32'h0);
    tick();
    check("ch8 rise one cycle", 32'(rise), 32'h0);
    check("ch8 status set", 32'({status, irq}), 32'({11'h100, 1'b1}));
    clr = 11'h100;
    tick();
    clr = '0;
    check("ch8 cleared", 32'({status, irq}), 32'h0);
    pad_ext = 11'h000;
    tick(2);
    check("ch8 fall", 32'(fall), 32'h100);
    tick();
    check("ch8 fall no status", 32'({status, irq}), 32'h0);
    en_rise = '0;
    tick(2);

    // 5. Clear colliding with a new rise on channel 0: set wins.
    en_rise = 11'h001; pad_ext = 11'h001;
    tick(3);
    check("ch0 first set", 32'(status), 32'h1);
    pad_ext = 11'h000;
    tick(4);
    pad_ext = 11'h001;
    tick(2);
    check("ch0 second rise", 32'(rise), 32'h1);
    clr = 11'h001;
    tick();
    clr = '0;
    check("ch0 set beats clear", 32'({status, irq}), 32'({11'h001, 1'b1}));
    clr = 11'h001;
    tick();
    clr = '0;
    check("ch0 clear alone", 32'({status, irq}), 32'h0);
    en_rise = '0; pad_ext = '0;
    tick(4);

    // 6. Reset aborts a 200-cycle pulse on channel 7 at cycle 50.
    pulse_len = 8'd200; pulse_start = 11'h080;
    tick();
    pulse_start = '0;
    tick(49);
    check("ch7 busy at cycle 50", 32'({busy[7], pad_oe[7], pad_out[7]}), 32'h7);
    rst_n = 1'b0;
    tick();
    check("ch7 released by reset", 32'({busy[7], pad_oe[7], pad_out[7]}), 32'h0);
    rst_n = 1'b1;
    tick(3);
    check("ch7 stays idle", 32'({busy[7], pad_oe[7]}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
